// File: rtl/pkt_rx_pkg.sv
// rtl/pkt_rx_pkg.sv - shared field layout and acceptance rule for pkt_receiver_param
package pkt_rx_pkg;

  localparam int SESSION_LSB = 0;
  localparam int SESSION_W   = 16;
  localparam int LEN_LSB     = 16;
  localparam int LEN_W       = 16;

  typedef struct packed {
    logic [LEN_W-1:0]     len;
    logic [SESSION_W-1:0] session;
  } rd_req_t;

  // Zero length is a connection close; partial beats and oversize messages are not handled downstream.
  function automatic logic accept_len(input logic [LEN_W-1:0] len, input int beat_bytes, input int max_len);
    int len_i;
    len_i = int'(len);
    return (len_i != 0) && ((len_i % beat_bytes) == 0) && (len_i <= max_len);
  endfunction

endpackage

// File: rtl/nukv_fifogen.sv
// rtl/nukv_fifogen.sv - synchronous FIFO with stream handshakes, head visible combinationally
module nukv_fifogen #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 push, pop;

  always_comb begin
    s_axis_tready = (count_q != (ADDR_BITS+1)'(DEPTH));
    m_axis_tvalid = (count_q != '0);
    m_axis_tdata  = mem_q[rd_ptr_q];
    push          = s_axis_tvalid & s_axis_tready;
    pop           = m_axis_tvalid & m_axis_tready;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
    if (push && !pop) count_d = count_q + (ADDR_BITS+1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_BITS+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

endmodule

// File: rtl/pkt_receiver_param.sv
// rtl/pkt_receiver_param.sv - TCP RX notification filter, credit-limited read requests, payload tagging
module pkt_receiver_param import pkt_rx_pkg::*; #(
  parameter int DATA_WIDTH      = 512,
  parameter int NOTIF_WIDTH     = 88,
  parameter int MAX_LEN         = 2048,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_ADDR_BITS  = 5,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                              ap_clk,
  input  logic                              rst,
  input  logic [NOTIF_WIDTH-1:0]            s_axis_notifications_TDATA,
  input  logic                              s_axis_notifications_TVALID,
  output logic                              s_axis_notifications_TREADY,
  input  logic [DATA_WIDTH:0]               s_axis_rx_data_TDATA,
  input  logic                              s_axis_rx_data_TVALID,
  output logic                              s_axis_rx_data_TREADY,
  output logic [31:0]                       m_axis_read_package_TDATA,
  output logic                              m_axis_read_package_TVALID,
  input  logic                              m_axis_read_package_TREADY,
  output logic [NOTIF_WIDTH+DATA_WIDTH:0]   pkt_tx_TDATA,
  output logic                              pkt_tx_TVALID,
  input  logic                              pkt_tx_TREADY,
  output logic [CNT_WIDTH-1:0]              drop_cnt,
  output logic [CNT_WIDTH-1:0]              len_err_cnt,
  output logic                              len_err
);

  localparam int                BEAT_BYTES   = DATA_WIDTH / 8;
  localparam logic [LEN_W-1:0]  BEAT_BYTES_L = LEN_W'(BEAT_BYTES);
  localparam logic [3:0]        MAX_OUT_L    = 4'(MAX_OUTSTANDING);

  logic [NOTIF_WIDTH-1:0] nf_data, md_data;
  logic                   nf_valid, nf_ready, md_valid, md_ready, md_in_ready;
  logic [DATA_WIDTH:0]    pl_data;
  logic                   pl_valid, pl_ready;

  logic [LEN_W-1:0]  nf_len, md_len, exp_last;
  logic              nf_accept, reject_pop, req_fire, tx_fire, last_fire, pl_last, mismatch;
  rd_req_t           req;

  logic [3:0]            outstanding_q, outstanding_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic                  sticky_q, sticky_d;
  logic                  len_err_q, len_err_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]  len_err_cnt_q, len_err_cnt_d;

  nukv_fifogen #(.DATA_SIZE(NOTIF_WIDTH), .ADDR_BITS(FIFO_ADDR_BITS)) u_notif_fifo (
    .clk(ap_clk), .rst(rst),
    .s_axis_tdata(s_axis_notifications_TDATA), .s_axis_tvalid(s_axis_notifications_TVALID),
    .s_axis_tready(s_axis_notifications_TREADY),
    .m_axis_tdata(nf_data), .m_axis_tvalid(nf_valid), .m_axis_tready(nf_ready)
  );

  nukv_fifogen #(.DATA_SIZE(DATA_WIDTH+1), .ADDR_BITS(FIFO_ADDR_BITS)) u_payload_fifo (
    .clk(ap_clk), .rst(rst),
    .s_axis_tdata(s_axis_rx_data_TDATA), .s_axis_tvalid(s_axis_rx_data_TVALID),
    .s_axis_tready(s_axis_rx_data_TREADY),
    .m_axis_tdata(pl_data), .m_axis_tvalid(pl_valid), .m_axis_tready(pl_ready)
  );

  nukv_fifogen #(.DATA_SIZE(NOTIF_WIDTH), .ADDR_BITS(FIFO_ADDR_BITS)) u_meta_fifo (
    .clk(ap_clk), .rst(rst),
    .s_axis_tdata(nf_data), .s_axis_tvalid(req_fire), .s_axis_tready(md_in_ready),
    .m_axis_tdata(md_data), .m_axis_tvalid(md_valid), .m_axis_tready(md_ready)
  );

  always_comb begin
    nf_len      = nf_data[LEN_LSB +: LEN_W];
    nf_accept   = accept_len(nf_len, BEAT_BYTES, MAX_LEN);
    req.len     = nf_len;
    req.session = nf_data[SESSION_LSB +: SESSION_W];

    reject_pop                 = nf_valid & ~nf_accept;
    m_axis_read_package_TVALID = nf_valid & nf_accept & md_in_ready & (outstanding_q < MAX_OUT_L);
    m_axis_read_package_TDATA  = req;
    req_fire                   = m_axis_read_package_TVALID & m_axis_read_package_TREADY;
    nf_ready                   = reject_pop | req_fire;

    pkt_tx_TVALID = pl_valid & md_valid;
    pkt_tx_TDATA  = {md_data, pl_data};
    pl_last       = pl_data[DATA_WIDTH];
    tx_fire       = pkt_tx_TVALID & pkt_tx_TREADY;
    last_fire     = tx_fire & pl_last;
    pl_ready      = tx_fire;
    md_ready      = last_fire;

    outstanding_d = outstanding_q;
    if (req_fire && !last_fire) outstanding_d = outstanding_q + 4'd1;
    else if (!req_fire && last_fire) outstanding_d = outstanding_q - 4'd1;

    drop_cnt_d = drop_cnt_q;
    if (reject_pop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);

    // Only accepted lengths reach the metadata FIFO, so E >= 1 and E-1 never wraps.
    md_len        = md_data[LEN_LSB +: LEN_W];
    exp_last      = (md_len / BEAT_BYTES_L) - LEN_W'(1);
    mismatch      = 1'b0;
    beat_d        = beat_q;
    sticky_d      = sticky_q;
    len_err_d     = 1'b0;
    len_err_cnt_d = len_err_cnt_q;
    if (tx_fire) begin
      mismatch = pl_last ? (beat_q != exp_last) : (beat_q == exp_last);
      if (mismatch && !sticky_q) begin
        len_err_d = 1'b1;
        if (len_err_cnt_q != '1) len_err_cnt_d = len_err_cnt_q + CNT_WIDTH'(1);
      end
      if (pl_last) begin
        beat_d   = '0;
        sticky_d = 1'b0;
      end else begin
        beat_d   = beat_q + LEN_W'(1);
        sticky_d = sticky_q | mismatch;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (rst) begin
      outstanding_q <= '0;
      beat_q        <= '0;
      sticky_q      <= 1'b0;
      len_err_q     <= 1'b0;
      drop_cnt_q    <= '0;
      len_err_cnt_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      beat_q        <= beat_d;
      sticky_q      <= sticky_d;
      len_err_q     <= len_err_d;
      drop_cnt_q    <= drop_cnt_d;
      len_err_cnt_q <= len_err_cnt_d;
    end
  end

  assign drop_cnt    = drop_cnt_q;
  assign len_err_cnt = len_err_cnt_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_pkt_receiver_param.sv
// tb/tb_pkt_receiver_param.sv - directed self-checking bench for pkt_receiver_param
module tb_pkt_receiver_param;

  localparam int DW  = 512;
  localparam int NW  = 88;
  localparam int TXW = NW + DW + 1;

  logic            ap_clk = 1'b0;
  logic            rst = 1'b1;
  logic [NW-1:0]   notif_tdata = '0;
  logic            notif_tvalid = 1'b0;
  logic            notif_tready;
  logic [DW:0]     rx_tdata = '0;
  logic            rx_tvalid = 1'b0;
  logic            rx_tready;
  logic [31:0]     rd_tdata;
  logic            rd_tvalid;
  logic            rd_tready = 1'b1;
  logic [TXW-1:0]  tx_tdata;
  logic            tx_tvalid;
  logic            tx_tready;
  logic [15:0]     drop_cnt, len_err_cnt;
  logic            len_err;

  logic toggle_en = 1'b0;
  logic tog = 1'b0;
  assign tx_tready = toggle_en ? tog : 1'b1;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) tog <= ~tog;

  pkt_receiver_param dut (
    .ap_clk(ap_clk), .rst(rst),
    .s_axis_notifications_TDATA(notif_tdata), .s_axis_notifications_TVALID(notif_tvalid),
    .s_axis_notifications_TREADY(notif_tready),
    .s_axis_rx_data_TDATA(rx_tdata), .s_axis_rx_data_TVALID(rx_tvalid), .s_axis_rx_data_TREADY(rx_tready),
    .m_axis_read_package_TDATA(rd_tdata), .m_axis_read_package_TVALID(rd_tvalid),
    .m_axis_read_package_TREADY(rd_tready),
    .pkt_tx_TDATA(tx_tdata), .pkt_tx_TVALID(tx_tvalid), .pkt_tx_TREADY(tx_tready),
    .drop_cnt(drop_cnt), .len_err_cnt(len_err_cnt), .len_err(len_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0]    req_log[$];
  logic [TXW-1:0] tx_log[$];
  int             err_pulses = 0;
  int             unstable = 0;
  logic           stalled = 1'b0;
  logic [TXW-1:0] held = '0;

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge ap_clk) begin
    if (!rst) begin
      if (rd_tvalid && rd_tready) req_log.push_back(rd_tdata);
      if (tx_tvalid && tx_tready) tx_log.push_back(tx_tdata);
      if (len_err) err_pulses++;
      if (stalled && (tx_tvalid !== 1'b1 || tx_tdata !== held)) unstable++;
      stalled = tx_tvalid && !tx_tready;
      held    = tx_tdata;
    end else begin
      stalled = 1'b0;
    end
  end

  function automatic logic [NW-1:0] notif(input int len, input int sess);
    return {8'hA5, 48'h0, 16'(len), 16'(sess)};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic push_notif(input int len, input int sess);
    notif_tdata  = notif(len, sess);
    notif_tvalid = 1'b1;
    wait_cyc(1);
    notif_tvalid = 1'b0;
  endtask

  task automatic push_beat(input logic [63:0] v, input logic last);
    rx_tdata  = {last, {8{v}}};
    rx_tvalid = 1'b1;
    wait_cyc(1);
    rx_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    req_log.delete();
    tx_log.delete();
    err_pulses = 0;
  endtask

  task automatic check_tx(input string tag, input int idx, input logic [NW-1:0] m,
                          input logic [63:0] v, input logic last);
    logic [TXW-1:0] t;
    check({tag, "_present"}, 128'(tx_log.size() > idx), 128'(1));
    if (tx_log.size() > idx) begin
      t = tx_log[idx];
      check({tag, "_meta"}, 128'(t[TXW-1 -: NW]), 128'(m));
      check({tag, "_last"}, 128'(t[DW]), 128'(last));
      check({tag, "_data"}, {t[DW-1 -: 64], t[63:0]}, {v, v});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_drop"}, 128'(drop_cnt), 128'(0));
    check({tag, "_lerrcnt"}, 128'(len_err_cnt), 128'(0));
    check({tag, "_lerr"}, 128'(len_err), 128'(0));
    check({tag, "_txvalid"}, 128'(tx_tvalid), 128'(0));
    check({tag, "_rdvalid"}, 128'(rd_tvalid), 128'(0));
    check({tag, "_rdy"}, 128'({notif_tready, rx_tready}), 128'(2'b11));
  endtask

  int base_req;
  int base_tx;

  initial begin
    do_reset();
    check_reset_state("rst0");

    // Single accepted message of two beats.
    push_notif(128, 7);
    wait_cyc(2);
    check("t1_req_cnt", 128'(req_log.size()), 128'(1));
    check("t1_req", 128'(req_log.size() > 0 ? req_log[0] : 32'h0), 128'(32'h0080_0007));
    push_beat(64'h1111_0000_0000_0001, 1'b0);
    push_beat(64'h1111_0000_0000_0002, 1'b1);
    wait_cyc(4);
    check("t1_tx_cnt", 128'(tx_log.size()), 128'(2));
    check_tx("t1_b0", 0, notif(128, 7), 64'h1111_0000_0000_0001, 1'b0);
    check_tx("t1_b1", 1, notif(128, 7), 64'h1111_0000_0000_0002, 1'b1);
    check("t1_lerrcnt", 128'(len_err_cnt), 128'(0));

    // Rejected lengths: close, non-multiple, oversize.
    push_notif(0, 1);
    push_notif(100, 2);
    push_notif(4096, 3);
    wait_cyc(4);
    check("t2_req_cnt", 128'(req_log.size()), 128'(1));
    check("t2_drop", 128'(drop_cnt), 128'(3));

    // Credit limit with payload withheld.
    base_req = req_log.size();
    base_tx  = tx_log.size();
    for (int i = 0; i < 6; i++) push_notif(64, 10 + i);
    wait_cyc(8);
    check("t3_req4", 128'(req_log.size() - base_req), 128'(4));
    check("t3_blocked", 128'(rd_tvalid), 128'(0));
    push_beat(64'h3333_0000_0000_0000, 1'b1);
    wait_cyc(4);
    check("t3_req5", 128'(req_log.size() - base_req), 128'(5));
    push_beat(64'h3333_0000_0000_0001, 1'b1);
    wait_cyc(4);
    check("t3_req6", 128'(req_log.size() - base_req), 128'(6));
    check("t3_req6_val", 128'(req_log[req_log.size()-1]), 128'(32'h0040_000F));
    for (int i = 2; i < 6; i++) push_beat(64'h3333_0000_0000_0000 + 64'(i), 1'b1);
    wait_cyc(6);
    check("t3_tx_cnt", 128'(tx_log.size() - base_tx), 128'(6));
    check_tx("t3_first", base_tx, notif(64, 10), 64'h3333_0000_0000_0000, 1'b1);
    check_tx("t3_last", base_tx + 5, notif(64, 15), 64'h3333_0000_0000_0005, 1'b1);
    check("t3_lerrcnt", 128'(len_err_cnt), 128'(0));

    // L=192 expects three beats; tlast on beat 1 is a mismatch.
    base_tx = tx_log.size();
    push_notif(192, 3);
    push_beat(64'h4444_0000_0000_0000, 1'b0);
    push_beat(64'h4444_0000_0000_0001, 1'b1);
    wait_cyc(6);
    check("t4_pulses", 128'(err_pulses), 128'(1));
    check("t4_lerrcnt", 128'(len_err_cnt), 128'(1));
    check_tx("t4_b0", base_tx, notif(192, 3), 64'h4444_0000_0000_0000, 1'b0);
    check_tx("t4_b1", base_tx + 1, notif(192, 3), 64'h4444_0000_0000_0001, 1'b1);

    // Output backpressure on alternate cycles.
    base_tx   = tx_log.size();
    toggle_en = 1'b1;
    push_notif(256, 5);
    for (int i = 0; i < 4; i++) push_beat(64'h5555_0000_0000_0000 + 64'(i), 1'(i == 3));
    wait_cyc(20);
    toggle_en = 1'b0;
    check("t5_tx_cnt", 128'(tx_log.size() - base_tx), 128'(4));
    for (int i = 0; i < 4; i++)
      check_tx($sformatf("t5_b%0d", i), base_tx + i, notif(256, 5), 64'h5555_0000_0000_0000 + 64'(i), 1'(i == 3));
    check("t5_unstable", 128'(unstable), 128'(0));
    check("t5_pulses", 128'(err_pulses), 128'(1));
    check("t5_lerrcnt", 128'(len_err_cnt), 128'(1));

    // Reset in the middle of a three-beat message.
    base_tx = tx_log.size();
    push_notif(192, 9);
    push_beat(64'h6666_0000_0000_0000, 1'b0);
    push_beat(64'h6666_0000_0000_0001, 1'b0);
    wait_cyc(4);
    check("t6_pre_tx", 128'(tx_log.size() - base_tx), 128'(2));
    do_reset();
    check_reset_state("t6_rst");
    push_notif(64, 4);
    push_beat(64'h7777_0000_0000_0000, 1'b1);
    wait_cyc(6);
    check("t6_req", 128'(req_log.size() > 0 ? req_log[0] : 32'h0), 128'(32'h0040_0004));
    check("t6_tx_cnt", 128'(tx_log.size()), 128'(1));
    check_tx("t6_b0", 0, notif(64, 4), 64'h7777_0000_0000_0000, 1'b1);
    check("t6_pulses", 128'(err_pulses), 128'(0));
    check("t6_lerrcnt", 128'(len_err_cnt), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
